// File: rtl/neander_premem_if.sv
// Memory port of the Neander front end: a single req/ack channel.
// The master (datapath front end) raises req with addr/we/wdata already valid.
// The slave (memory) completes the access by returning ack. For reads,
// rdata must be valid in the same cycle as ack.
// Signals: req, we, addr, wdata (master->slave); rdata, ack (slave->master).
interface neander_premem_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output req, output we, output addr, output wdata,
                  input  rdata, input ack);
  modport slave  (input  req, input  we, input  addr, input  wdata,
                  output rdata, output ack);
endinterface

// File: rtl/neander_premem.sv
// neander_premem -- memory-side front end of the Neander datapath.
// It owns PC, REM and the RI opcode field. It sequences these accesses
// over a req/ack port:
//   - instruction fetch
//   - operand-address fetch
//   - data read
//   - STA write
// It then hands the operand, usel and a one-cycle load strobe to the
// accumulator/ULA stage.
// Ports:
//   clock, nreset        single clock, asynchronous active-low reset
//   mem (master)         req/we/addr/wdata out, rdata/ack in
//   ac, ac_zero, ac_neg  accumulator value and flags from the ULA stage
//   operando, usel       operand and ULA select for the ULA stage
//   ac_we, ac_ld         one-cycle strobes: ALU result load / LDA load
//   pc, halted, err      program counter, HALT indication, sticky timeout
// Optional feature, controlled by the macro MEM_TIMEOUT_EN:
//   When defined, an access that waits TIMEOUT_CYC cycles without ack
//   is abandoned. err is then set and the machine halts.
module neander_premem #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 8,
  parameter logic [ADDR_W-1:0] RESET_PC    = {ADDR_W{1'b0}},
  parameter int                TIMEOUT_CYC = 15
) (
  input  logic                  clock,
  input  logic                  nreset,
  neander_premem_if.master      mem,
  input  logic [DATA_W-1:0]     ac,
  input  logic                  ac_zero,
  input  logic                  ac_neg,
  output logic [DATA_W-1:0]     operando,
  output logic [1:0]            usel,
  output logic                  ac_we,
  output logic                  ac_ld,
  output logic [ADDR_W-1:0]     pc,
  output logic                  halted,
  output logic                  err
);
  typedef enum logic [2:0] {
    F_OP   = 3'd0,
    DEC    = 3'd1,
    F_ADDR = 3'd2,
    EX_RD  = 3'd3,
    EX_AC  = 3'd4,
    EX_WR  = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0, OP_STA = 4'h1, OP_LDA = 4'h2, OP_ADD = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4, OP_AND = 4'h5, OP_NOT = 4'h6, OP_JMP = 4'h8;
  localparam logic [3:0] OP_JN  = 4'h9, OP_JZ  = 4'hA, OP_HLT = 4'hF;

  state_t              state_r, state_nxt;
  logic [ADDR_W-1:0]   pc_r, pc_nxt, rem_r, rem_nxt, addr_r, addr_nxt;
  logic [3:0]          op_r, op_nxt;
  logic [DATA_W-1:0]   wdata_r, wdata_nxt, operando_r, operando_nxt;
  logic [1:0]          usel_r, usel_nxt;
  logic                req_r, req_nxt, we_r, we_nxt;
  logic                ac_we_r, ac_we_nxt, ac_ld_r, ac_ld_nxt;
  logic                halted_r, err_r, err_nxt;
  logic                done_s;
  logic [ADDR_W-1:0]   pc_inc_s;
  logic [3:0]          rd_op_s;

`ifdef MEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_r, tmo_nxt;
`endif

  assign done_s   = req_r & mem.ack;
  assign pc_inc_s = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign rd_op_s  = mem.rdata[DATA_W-1 -: 4];

  assign mem.req   = req_r;
  assign mem.we    = we_r;
  assign mem.addr  = addr_r;
  assign mem.wdata = wdata_r;
  assign operando  = operando_r;
  assign usel      = usel_r;
  assign ac_we     = ac_we_r;
  assign ac_ld     = ac_ld_r;
  assign pc        = pc_r;
  assign halted    = halted_r;
  assign err       = err_r;

  // Next-state and next-output logic. Every memory state first spends one
  // idle cycle raising req, then holds req until ack completes the access.
  always_comb begin
    state_nxt    = state_r;
    pc_nxt       = pc_r;
    rem_nxt      = rem_r;
    op_nxt       = op_r;
    addr_nxt     = addr_r;
    wdata_nxt    = wdata_r;
    operando_nxt = operando_r;
    usel_nxt     = usel_r;
    req_nxt      = req_r;
    we_nxt       = we_r;
    ac_we_nxt    = 1'b0;
    ac_ld_nxt    = 1'b0;
    err_nxt      = err_r;
`ifdef MEM_TIMEOUT_EN
    tmo_nxt      = tmo_r;
`endif
    case (state_r)
      F_OP: begin
        if (!req_r) begin
          req_nxt  = 1'b1;
          we_nxt   = 1'b0;
          addr_nxt = pc_r;
        end else if (done_s) begin
          req_nxt   = 1'b0;
          op_nxt    = rd_op_s;
          pc_nxt    = pc_inc_s;
          state_nxt = DEC;
          // NOT needs no operand. Its strobe is raised here so it is
          // visible during the DEC cycle.
          if (rd_op_s == OP_NOT) begin
            ac_we_nxt = 1'b1;
            usel_nxt  = 2'b11;
          end else begin
            ac_we_nxt = 1'b0;
          end
        end else begin
          req_nxt = 1'b1;
        end
      end
      DEC: begin
        case (op_r)
          OP_HLT:                             state_nxt = HALT;
          OP_STA, OP_LDA, OP_ADD, OP_OR,
          OP_AND, OP_JMP, OP_JN, OP_JZ:       state_nxt = F_ADDR;
          default:                            state_nxt = F_OP;
        endcase
      end
      F_ADDR: begin
        if (!req_r) begin
          req_nxt  = 1'b1;
          we_nxt   = 1'b0;
          addr_nxt = pc_r;
        end else if (done_s) begin
          req_nxt   = 1'b0;
          rem_nxt   = mem.rdata[ADDR_W-1:0];
          pc_nxt    = pc_inc_s;
          state_nxt = F_OP;
          case (op_r)
            OP_JMP: pc_nxt = mem.rdata[ADDR_W-1:0];
            OP_JN: begin
              if (ac_neg) pc_nxt = mem.rdata[ADDR_W-1:0];
              else        pc_nxt = pc_inc_s;
            end
            OP_JZ: begin
              if (ac_zero) pc_nxt = mem.rdata[ADDR_W-1:0];
              else         pc_nxt = pc_inc_s;
            end
            OP_STA: begin
              wdata_nxt = ac;
              state_nxt = EX_WR;
            end
            OP_LDA, OP_ADD, OP_OR, OP_AND: state_nxt = EX_RD;
            default:                       state_nxt = F_OP;
          endcase
        end else begin
          req_nxt = 1'b1;
        end
      end
      EX_RD: begin
        if (!req_r) begin
          req_nxt  = 1'b1;
          we_nxt   = 1'b0;
          addr_nxt = rem_r;
        end else if (done_s) begin
          req_nxt      = 1'b0;
          operando_nxt = mem.rdata;
          state_nxt    = EX_AC;
          // The strobe is raised here so that it coincides with the EX_AC cycle.
          case (op_r)
            OP_LDA:  ac_ld_nxt = 1'b1;
            OP_ADD:  begin ac_we_nxt = 1'b1; usel_nxt = 2'b00; end
            OP_OR:   begin ac_we_nxt = 1'b1; usel_nxt = 2'b01; end
            OP_AND:  begin ac_we_nxt = 1'b1; usel_nxt = 2'b10; end
            default: ac_we_nxt = 1'b0;
          endcase
        end else begin
          req_nxt = 1'b1;
        end
      end
      EX_AC:   state_nxt = F_OP;
      EX_WR: begin
        if (!req_r) begin
          req_nxt  = 1'b1;
          we_nxt   = 1'b1;
          addr_nxt = rem_r;
        end else if (done_s) begin
          req_nxt   = 1'b0;
          we_nxt    = 1'b0;
          state_nxt = F_OP;
        end else begin
          req_nxt = 1'b1;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = F_OP;
    endcase
`ifdef MEM_TIMEOUT_EN
    // Only stalled cycles are counted. If ack arrives in the limit cycle,
    // done_s is set, this branch is not taken and no error is raised.
    if (req_r && !mem.ack) begin
      if (tmo_r == TMO_LAST) begin
        req_nxt   = 1'b0;
        we_nxt    = 1'b0;
        err_nxt   = 1'b1;
        state_nxt = HALT;
        tmo_nxt   = {TMO_W{1'b0}};
      end else begin
        tmo_nxt = tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
      end
    end else begin
      tmo_nxt = {TMO_W{1'b0}};
    end
`endif
  end

  // State and registered-output update; reset drops any pending request at once.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_r    <= F_OP;
      pc_r       <= RESET_PC;
      rem_r      <= {ADDR_W{1'b0}};
      op_r       <= 4'h0;
      addr_r     <= {ADDR_W{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
      operando_r <= {DATA_W{1'b0}};
      usel_r     <= 2'b00;
      req_r      <= 1'b0;
      we_r       <= 1'b0;
      ac_we_r    <= 1'b0;
      ac_ld_r    <= 1'b0;
      halted_r   <= 1'b0;
      err_r      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      tmo_r      <= {TMO_W{1'b0}};
`endif
    end else begin
      state_r    <= state_nxt;
      pc_r       <= pc_nxt;
      rem_r      <= rem_nxt;
      op_r       <= op_nxt;
      addr_r     <= addr_nxt;
      wdata_r    <= wdata_nxt;
      operando_r <= operando_nxt;
      usel_r     <= usel_nxt;
      req_r      <= req_nxt;
      we_r       <= we_nxt;
      ac_we_r    <= ac_we_nxt;
      ac_ld_r    <= ac_ld_nxt;
      halted_r   <= (state_nxt == HALT);
      err_r      <= err_nxt;
`ifdef MEM_TIMEOUT_EN
      tmo_r      <= tmo_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_neander_premem.sv
// Directed bench for neander_premem.
// Each table vector does the following:
//   - loads a one-instruction program at 0x00/0x01 into a memory that is
//     otherwise filled with HLT (0xF0)
//   - runs until the DUT halts
//   - compares pc, operando, usel, the strobe counts and the writes
// Hand-written sequences then cover these cases:
//   - reset values
//   - ADD strobe latency
//   - PC wrap
//   - HALT quiescence
//   - ack timeout
//   - reset in the middle of an access
module tb_neander_premem;
  logic       clock, nreset;
  logic [7:0] ac, operando, pc;
  logic       ac_zero, ac_neg, ac_we, ac_ld, halted, err;
  logic [1:0] usel;

  neander_premem_if #(.ADDR_W(8), .DATA_W(8)) mem_if ();

  neander_premem dut (
    .clock(clock), .nreset(nreset), .mem(mem_if),
    .ac(ac), .ac_zero(ac_zero), .ac_neg(ac_neg),
    .operando(operando), .usel(usel), .ac_we(ac_we), .ac_ld(ac_ld),
    .pc(pc), .halted(halted), .err(err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory model with a configurable number of wait states.
  logic [7:0] mem [0:255];
  int         wait_n, wcnt;
  logic       ack_en, clr;
  int         we_cnt, ld_cnt, both_cnt, wr_cnt, drop_cnt;
  logic [7:0] wr_addr, wr_data;
  logic       req_q, ack_q;

  assign mem_if.ack   = mem_if.req && ack_en && (wcnt == wait_n);
  assign mem_if.rdata = mem[mem_if.addr];

  always @(posedge clock) begin
    if (clr) begin
      wcnt <= 0; we_cnt <= 0; ld_cnt <= 0; both_cnt <= 0; wr_cnt <= 0; drop_cnt <= 0;
      wr_addr <= 8'h00; wr_data <= 8'h00; req_q <= 1'b0; ack_q <= 1'b0;
    end else begin
      if (mem_if.req && !mem_if.ack) wcnt <= wcnt + 1;
      else                           wcnt <= 0;
      if (mem_if.req && mem_if.ack && mem_if.we) begin
        wr_cnt  <= wr_cnt + 1;
        wr_addr <= mem_if.addr;
        wr_data <= mem_if.wdata;
      end
      if (ac_we)           we_cnt   <= we_cnt + 1;
      if (ac_ld)           ld_cnt   <= ld_cnt + 1;
      if (ac_we && ac_ld)  both_cnt <= both_cnt + 1;
      req_q <= mem_if.req;
      ack_q <= mem_if.ack;
      if (req_q && !ack_q && !mem_if.req) drop_cnt <= drop_cnt + 1;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Holds the DUT in reset, loads memory, then releases reset at a negedge.
  task automatic start(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] da,
                       input logic [7:0] dv, input logic [7:0] a, input logic z,
                       input logic n, input int w, input logic ae);
    nreset = 1'b0;
    clr = 1'b1;
    ac = a; ac_zero = z; ac_neg = n; wait_n = w; ack_en = ae;
    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    mem[da] = dv;
    mem[0] = b0;
    mem[1] = b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    nreset = 1'b1;
    clr = 1'b0;
  endtask

  task automatic wait_halt(input int max, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clock);
      if (halted) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    string      name;
    logic [7:0] b0, b1, da, dv, a;
    logic       z, n;
    int         waits;
    logic [7:0] e_pc, e_opnd;
    logic [1:0] e_usel;
    int         e_we, e_ld, e_wr;
    logic [7:0] e_wa, e_wd;
  } vec_t;

  vec_t vecs [15];

  initial begin
    logic ok;
    int   cyc, req_hi, phase;

    vecs[0]  = '{"lda",    8'h20, 8'h80, 8'h80, 8'h05, 8'h5A, 1'b0, 1'b0, 0, 8'h03, 8'h05, 2'b00, 0, 1, 0, 8'h00, 8'h00};
    vecs[1]  = '{"add",    8'h30, 8'h81, 8'h81, 8'h07, 8'h5A, 1'b0, 1'b0, 0, 8'h03, 8'h07, 2'b00, 1, 0, 0, 8'h00, 8'h00};
    vecs[2]  = '{"or",     8'h40, 8'h82, 8'h82, 8'h3C, 8'h5A, 1'b0, 1'b0, 0, 8'h03, 8'h3C, 2'b01, 1, 0, 0, 8'h00, 8'h00};
    vecs[3]  = '{"and",    8'h50, 8'h83, 8'h83, 8'hC3, 8'h5A, 1'b0, 1'b0, 0, 8'h03, 8'hC3, 2'b10, 1, 0, 0, 8'h00, 8'h00};
    vecs[4]  = '{"not",    8'h60, 8'hF0, 8'h80, 8'h11, 8'h5A, 1'b0, 1'b0, 0, 8'h02, 8'h00, 2'b11, 1, 0, 0, 8'h00, 8'h00};
    vecs[5]  = '{"sta_w3", 8'h10, 8'h90, 8'h90, 8'h33, 8'hA5, 1'b0, 1'b0, 3, 8'h03, 8'h00, 2'b00, 0, 0, 1, 8'h90, 8'hA5};
    vecs[6]  = '{"jz_t",   8'hA0, 8'h40, 8'h80, 8'h00, 8'h00, 1'b1, 1'b0, 0, 8'h41, 8'h00, 2'b00, 0, 0, 0, 8'h00, 8'h00};
    vecs[7]  = '{"jz_n",   8'hA0, 8'h40, 8'h80, 8'h00, 8'h01, 1'b0, 1'b0, 0, 8'h03, 8'h00, 2'b00, 0, 0, 0, 8'h00, 8'h00};
    vecs[8]  = '{"jn_t",   8'h90, 8'h50, 8'h80, 8'h00, 8'h80, 1'b0, 1'b1, 0, 8'h51, 8'h00, 2'b00, 0, 0, 0, 8'h00, 8'h00};
    vecs[9]  = '{"jn_n",   8'h90, 8'h50, 8'h80, 8'h00, 8'h01, 1'b0, 1'b0, 0, 8'h03, 8'h00, 2'b00, 0, 0, 0, 8'h00, 8'h00};
    vecs[10] = '{"jmp",    8'h80, 8'h60, 8'h80, 8'h00, 8'h5A, 1'b1, 1'b1, 0, 8'h61, 8'h00, 2'b00, 0, 0, 0, 8'h00, 8'h00};
    vecs[11] = '{"nop",    8'h00, 8'hF0, 8'h80, 8'h00, 8'h5A, 1'b0, 1'b0, 0, 8'h02, 8'h00, 2'b00, 0, 0, 0, 8'h00, 8'h00};
    vecs[12] = '{"undef",  8'h70, 8'hF0, 8'h80, 8'h00, 8'h5A, 1'b0, 1'b0, 0, 8'h02, 8'h00, 2'b00, 0, 0, 0, 8'h00, 8'h00};
    vecs[13] = '{"add_w2", 8'h30, 8'h85, 8'h85, 8'h99, 8'h5A, 1'b0, 1'b0, 2, 8'h03, 8'h99, 2'b00, 1, 0, 0, 8'h00, 8'h00};
    vecs[14] = '{"lda_w1", 8'h20, 8'h84, 8'h84, 8'h7E, 8'h5A, 1'b0, 1'b0, 1, 8'h03, 8'h7E, 2'b00, 0, 1, 0, 8'h00, 8'h00};

    // Reset values, sampled while nreset is held low.
    nreset = 1'b0; clr = 1'b1; ac = 8'h00; ac_zero = 1'b0; ac_neg = 1'b0; wait_n = 0; ack_en = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_outs", {mem_if.req, mem_if.we, mem_if.addr, mem_if.wdata, operando, usel, ac_we, ac_ld, halted, err},
          32'h0);
    check("reset_pc", {24'h0, pc}, 32'h0);

    // Table vectors.
    for (int v = 0; v < 15; v++) begin
      start(vecs[v].b0, vecs[v].b1, vecs[v].da, vecs[v].dv, vecs[v].a, vecs[v].z, vecs[v].n, vecs[v].waits, 1'b1);
      wait_halt(400, ok);
      check({vecs[v].name, "_halt"}, {31'h0, ok}, 32'h1);
      check({vecs[v].name, "_pc"}, {24'h0, pc}, {24'h0, vecs[v].e_pc});
      check({vecs[v].name, "_operando"}, {24'h0, operando}, {24'h0, vecs[v].e_opnd});
      check({vecs[v].name, "_usel"}, {30'h0, usel}, {30'h0, vecs[v].e_usel});
      check({vecs[v].name, "_ac_we_cnt"}, we_cnt, vecs[v].e_we);
      check({vecs[v].name, "_ac_ld_cnt"}, ld_cnt, vecs[v].e_ld);
      check({vecs[v].name, "_both_strobes"}, both_cnt, 32'h0);
      check({vecs[v].name, "_wr_cnt"}, wr_cnt, vecs[v].e_wr);
      check({vecs[v].name, "_req_drop"}, drop_cnt, 32'h0);
      check({vecs[v].name, "_err"}, {31'h0, err}, 32'h0);
      if (vecs[v].e_wr > 0) begin
        check({vecs[v].name, "_wr_addr"}, {24'h0, wr_addr}, {24'h0, vecs[v].e_wa});
        check({vecs[v].name, "_wr_data"}, {24'h0, wr_data}, {24'h0, vecs[v].e_wd});
      end
    end

    // ADD strobe latency with a zero-wait memory: ac_we is high 7 cycles after F_OP starts.
    start(8'h30, 8'h81, 8'h81, 8'h07, 8'h00, 1'b0, 1'b0, 0, 1'b1);
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (ac_we) begin
        cyc = i;
        break;
      end
    end
    check("add_latency", cyc, 32'd7);
    check("add_latency_usel", {30'h0, usel}, 32'h0);

    // PC wrap: JMP 0xFF, NOP at 0xFF, so the next fetch must be at 0x00.
    start(8'h80, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 0, 1'b1);
    phase = 0;
    for (int i = 0; i < 60 && phase < 3; i++) begin
      @(negedge clock);
      if (phase == 0 && mem_if.req && mem_if.addr == 8'hFF) phase = 1;
      else if (phase == 1 && !mem_if.req) phase = 2;
      else if (phase == 2 && mem_if.req) phase = 3;
    end
    check("wrap_reached", phase, 32'd3);
    check("wrap_fetch_addr", {24'h0, mem_if.addr}, 32'h0);
    check("wrap_pc", {24'h0, pc}, 32'h0);

    // HALT at 0x00: no further requests for 50 cycles.
    start(8'hF0, 8'hF0, 8'h80, 8'hF0, 8'h00, 1'b0, 1'b0, 0, 1'b1);
    wait_halt(20, ok);
    check("hlt_halted", {31'h0, ok}, 32'h1);
    req_hi = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (mem_if.req) req_hi++;
    end
    check("hlt_req_quiet", req_hi, 32'h0);
    check("hlt_pc", {24'h0, pc}, 32'h1);
    check("hlt_still_halted", {31'h0, halted}, 32'h1);

    // Memory that never acknowledges.
    start(8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 1'b0, 1'b0, 0, 1'b0);
    req_hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (mem_if.req) req_hi++;
    end
`ifdef MEM_TIMEOUT_EN
    check("tmo_req_cycles", req_hi, 32'd15);
    check("tmo_err", {31'h0, err}, 32'h1);
    check("tmo_halted", {31'h0, halted}, 32'h1);
    check("tmo_req_low", {31'h0, mem_if.req}, 32'h0);
`else
    check("noack_req_cycles", req_hi, 32'd40);
    check("noack_err", {31'h0, err}, 32'h0);
    check("noack_req_high", {31'h0, mem_if.req}, 32'h1);
`endif

    // Reset in the middle of an access drops req immediately.
    start(8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 1'b0, 1'b0, 0, 1'b0);
    repeat (3) @(negedge clock);
    check("mid_req_pending", {31'h0, mem_if.req}, 32'h1);
    #2 nreset = 1'b0;
    #1;
    check("mid_reset_req", {31'h0, mem_if.req}, 32'h0);
    check("mid_reset_pc", {24'h0, pc}, 32'h0);
    check("mid_reset_halted", {31'h0, halted}, 32'h0);
    @(negedge clock);
    nreset = 1'b1;
    repeat (2) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
